// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state type and counter-width helper for the bit-serial adder
package serial_adder_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction
endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder around one full_adder with valid/ready on both sides
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = cnt_width(WIDTH);
    sa_state_t state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
    logic [CW-1:0] cnt;
    logic carry, fa_sum, fa_carry, last;
    full_adder u_fa (
        .a(a_sr[0]),
        .b(b_sr[0]),
        .cin(carry),
        .sum(fa_sum),
        .carry(fa_carry)
    );
    assign last = cnt == CW'(WIDTH - 1);
    always_comb begin
        state_nx  = (state == IDLE && in_valid) ? RUN :
                    (state == RUN && last) ? DONE :
                    (state == DONE && out_ready) ? IDLE : state;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
        sum       = out_valid ? sum_sr : '0;
        cout      = out_valid ? carry : 1'b0;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    // Sum bits enter at the MSB so after WIDTH shifts the LSB lands in bit 0.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (state == IDLE && in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            sum_sr <= '0;
            carry  <= cin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= WIDTH'({fa_sum, sum_sr} >> 1);
            carry  <= fa_carry;
            cnt    <= cnt + 1'b1;
        end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;
    logic clk = 0, rst = 1;
    logic in_valid = 0, out_ready = 0, cin = 0;
    logic in_ready, out_valid, cout, busy;
    logic [7:0] a = 0, b = 0, sum;
    logic in_valid1 = 0, out_ready1 = 0, a1 = 0, b1 = 0, cin1 = 0;
    logic in_ready1, out_valid1, sum1, cout1, busy1;
    int errors = 0, checks = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, sum, cout, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset8: rdy=%b ov=%b sum=%h cout=%b busy=%b, want 1 0 00 0 0",
                     in_ready, out_valid, sum, cout, busy);
        end
        checks++;
        if ({in_ready1, out_valid1, sum1, cout1, busy1} !== 5'b10000) begin
            errors++;
            $display("FAIL reset1: got %b, want 10000", {in_ready1, out_valid1, sum1, cout1, busy1});
        end
        rst = 0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: rdy=%b busy=%b, want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_directed();
        int va[3] = '{'h5A, 'hFF, 'hFF};
        int vb[3] = '{'h3C, 'h01, 'hFF};
        int vc[3] = '{0, 0, 1};
        for (int i = 0; i < 3; i++) begin
            int e;
            e = va[i] + vb[i] + vc[i];
            @(negedge clk);
            a = 8'(va[i]); b = 8'(vb[i]); cin = 1'(vc[i]); in_valid = 1; out_ready = 1;
            @(negedge clk);
            in_valid = 0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL accept_%0d: rdy=%b busy=%b, want 0 1", i, in_ready, busy);
            end
            for (int j = 1; j <= 8; j++) begin
                @(negedge clk);
                checks++;
                if (out_valid !== (j == 8)) begin
                    errors++;
                    $display("FAIL latency_%0d_c%0d: out_valid=%b, want %b", i, j, out_valid, j == 8);
                end
                if (j < 8) begin
                    checks++;
                    if (sum !== 8'h00 || cout !== 1'b0) begin
                        errors++;
                        $display("FAIL gate_%0d_c%0d: sum=%h cout=%b, want 00 0", i, j, sum, cout);
                    end
                end else begin
                    checks++;
                    if ({cout, sum} !== 9'(e)) begin
                        errors++;
                        $display("FAIL sum_%0d: got %h, want %h", i, {cout, sum}, 9'(e));
                    end
                end
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL release_%0d: ov=%b rdy=%b, want 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] ta, tb_;
        logic tc;
        int e;
        ta = 8'($urandom); tb_ = 8'($urandom); tc = 1'($urandom);
        e = int'(ta) + int'(tb_) + int'(tc);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; in_valid = 1; out_ready = 0;
        @(negedge clk);
        in_valid = 0;
        repeat (8) @(negedge clk);
        for (int j = 0; j <= 5; j++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== 9'(e)) begin
                errors++;
                $display("FAIL hold_%0d: ov=%b rdy=%b res=%h, want 1 0 %h",
                         j, out_valid, in_ready, {cout, sum}, 9'(e));
            end
            if (j < 5) begin
                in_valid = ~in_valid; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1; out_ready = 1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL both_hs: rdy=%b busy=%b ov=%b, want 1 0 0", in_ready, busy, out_valid);
        end
        in_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 0; in_valid = 1; out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (3) @(negedge clk);
        #1 rst = 1;
        #1;
        checks++;
        if ({in_ready, out_valid, sum, cout, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_rst: rdy=%b ov=%b sum=%h cout=%b busy=%b, want 1 0 00 0 0",
                     in_ready, out_valid, sum, cout, busy);
        end
        #1 rst = 0;
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 0; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (j == 8)) begin
                errors++;
                $display("FAIL post_rst_c%0d: out_valid=%b, want %b", j, out_valid, j == 8);
            end
        end
        checks++;
        if (sum !== 8'h03 || cout !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_sum: got %h/%b, want 03/0", sum, cout);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] qa[4], qb[4];
        logic qc[4];
        int exp_q[$];
        int n_acc = 0, n_res = 0, last_cyc = -1, e;
        logic prev_rdy;
        for (int i = 0; i < 4; i++) begin
            qa[i] = 8'($urandom); qb[i] = 8'($urandom); qc[i] = 1'($urandom);
        end
        @(negedge clk);
        a = qa[0]; b = qb[0]; cin = qc[0]; in_valid = 1; out_ready = 1;
        prev_rdy = in_ready;
        for (int t = 0; t < 80 && n_res < 4; t++) begin
            @(negedge clk);
            if (prev_rdy && in_valid) begin
                exp_q.push_back(int'(qa[n_acc]) + int'(qb[n_acc]) + int'(qc[n_acc]));
                n_acc++;
                if (n_acc < 4) begin
                    a = qa[n_acc]; b = qb[n_acc]; cin = qc[n_acc];
                end else in_valid = 0;
            end
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: result %h with none pending", {cout, sum});
                end else begin
                    e = exp_q.pop_front();
                    if ({cout, sum} !== 9'(e)) begin
                        errors++;
                        $display("FAIL b2b_sum_%0d: got %h, want %h", n_res, {cout, sum}, 9'(e));
                    end
                end
                if (last_cyc >= 0) begin
                    checks++;
                    if (cyc - last_cyc != 10) begin
                        errors++;
                        $display("FAIL b2b_gap_%0d: got %0d cycles, want 10", n_res, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                n_res++;
            end
            prev_rdy = in_ready;
        end
        checks++;
        if (n_res != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, want 4", n_res);
        end
        in_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_width1();
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            int e;
            v = 3'(i);
            e = int'(v[2]) + int'(v[1]) + int'(v[0]);
            @(negedge clk);
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; in_valid1 = 1; out_ready1 = 1;
            @(negedge clk);
            in_valid1 = 0;
            checks++;
            if (busy1 !== 1'b1 || out_valid1 !== 1'b0) begin
                errors++;
                $display("FAIL w1_run_%0d: busy=%b ov=%b, want 1 0", i, busy1, out_valid1);
            end
            @(negedge clk);
            checks++;
            if (out_valid1 !== 1'b1 || {cout1, sum1} !== 2'(e)) begin
                errors++;
                $display("FAIL w1_sum_%0d: ov=%b res=%b, want 1 %b", i, out_valid1, {cout1, sum1}, 2'(e));
            end
            @(negedge clk);
            checks++;
            if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
                errors++;
                $display("FAIL w1_idle_%0d: rdy=%b ov=%b, want 1 0", i, in_ready1, out_valid1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_width1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder that sits directly above the existing full_adder cell and feeds it one bit pair per clock.
- Accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake.
- Streams the operands LSB-first through a single full_adder instance, with a registered carry fed back on each cycle.
- Presents the WIDTH-bit sum and the carry-out through a second valid/ready handshake.
- Serves as the area-minimal adder alternative to a ripple chain of full_adder cells.

Parameters:
- WIDTH, 8: operand and sum width in bits; legal range is 1 or greater.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand bundle (a, b, cin) is valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result is valid; high only in DONE.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result (a+b+cin) mod 2^WIDTH; forced to 0 when out_valid=0.
- cout  output  1  carry-out of bit WIDTH-1; forced to 0 when out_valid=0.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: rst is asynchronous and active-high. Asserting it at any time, including mid-RUN or in DONE, immediately sets:
  - state to IDLE and all shift, carry and counter registers to 0;
  - in_ready=1, out_valid=0, sum=0, cout=0, busy=0.
- In-flight operands are discarded on reset; no result is produced for them.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1, load a_sr<=a, b_sr<=b, carry<=cin, sum_sr<=0, cnt<=0, and go to RUN.
  - Inputs are ignored when in_valid=0.
- RUN:
  - in_ready=0.
  - Each edge feeds full_adder(a_sr[0], b_sr[0], carry).
  - sum_sr shifts right with the full_adder sum bit entering at the MSB.
  - a_sr and b_sr shift right with zero fill.
  - carry<=full_adder carry; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1 (the last bit is processed), go to DONE.
  - RUN lasts exactly WIDTH cycles.
- DONE:
  - out_valid=1, sum=sum_sr, cout=carry.
  - Outputs stay stable while out_ready=0; there is no timeout.
  - On an edge with out_ready=1, go to IDLE.
  - in_valid is ignored in DONE; the block does not overlap accept and present.
- Latency: operands accepted at edge k. out_valid is high in the cycle following edge k+WIDTH.
- Throughput: with out_ready held at 1, the next accept occurs at edge k+WIDTH+2, giving one result per WIDTH+2 cycles.
- Width rules:
  - cnt is $clog2(WIDTH+1) bits wide, so WIDTH=1 is legal.
  - The sum wraps mod 2^WIDTH; overflow is reported only via cout.
- Input stability: inputs are sampled only on the accept edge. Changes to a, b or cin after acceptance have no effect.
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes; the input is accepted in IDLE on a later edge.
- sum and cout are gated combinationally by the DONE state. The internal shifting register is never visible on the outputs.

Decomposition:
- Shared package serial_adder_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;
  - the localparam helper for counter width.
- One sub-module: the existing full_adder, instantiated once as the per-bit datapath (ports a, b, cin, sum, carry).
- The FSM, shift registers and carry flop live in serial_adder.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, out_ready=1 -> out_valid high in cycle k+9 for exactly one cycle; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a/b.
  - sum, cout and out_valid stay stable; in_ready stays 0; no new operand is accepted.
  - After out_ready=1: IDLE on the next edge.
- Reset mid-operation: assert rst after 3 RUN cycles of 0x12+0x34.
  - Outputs go to 0 and in_ready=1 immediately, without waiting for a clock.
  - After release, 0x01+0x02 yields sum=0x03 with no trace of the aborted op.
- Back-to-back with in_valid and out_ready tied to 1 over 4 random operand sets:
  - results match (a+b+cin) mod 256 with the correct cout;
  - out_valid pulses exactly 10 cycles apart.
- WIDTH=1 instance: all 8 combinations of a, b, cin -> sum/cout match the full-adder truth table; RUN lasts 1 cycle.
